// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode constants, instruction field positions and fetch FSM encoding.
// Control imports the same package so both sides agree on the opcode space.
package risc_pkg;

    localparam logic [6:0] OP_LW    = 7'b0110000;
    localparam logic [6:0] OP_SW    = 7'b0110001;
    localparam logic [6:0] OP_JR    = 7'b1000001;
    localparam logic [2:0] BR_CLASS = 3'b100;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 25;
    localparam int IMM_HI = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        RESOLVE = 2'd3
    } fetchState_e;

    // Every opcode in the branch class waits for an outcome before the next fetch.
    function automatic logic isBranch(input logic [6:0] op);
        return op[6:4] == BR_CLASS;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the imem request channel, the issue channel toward Control/datapath
// and the branch-resolution inputs of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    logic               issue_valid;
    logic               issue_ready;
    logic [6:0]         operation;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  issue_pc;

    logic               br_valid;
    logic               br_taken;
    logic [ADDR_W-1:0]  rs_value;

    logic [CNT_W-1:0]   issue_count;

    modport master (
        output imem_req, imem_addr, issue_valid, operation, instr, issue_pc, issue_count,
        input  imem_ready, imem_rdata, issue_ready, br_valid, br_taken, rs_value
    );

    modport slave (
        input  imem_req, imem_addr, issue_valid, operation, instr, issue_pc, issue_count,
        output imem_ready, imem_rdata, issue_ready, br_valid, br_taken, rs_value
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Branch-target arithmetic for the fetch unit: jump-register, taken branch or
// fall-through. All sums wrap modulo 2^ADDR_W.
module next_pc_calc
    import risc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [IMM_HI:0]   instrImm,
    input  logic              brTaken,
    input  logic [ADDR_W-1:0] rsValue,
    input  logic              isJr,
    output logic [ADDR_W-1:0] nextPc
);

    logic [ADDR_W-1:0] seqPc;
    logic [ADDR_W-1:0] branchOffset;

    // Immediate is a signed word offset relative to the following instruction.
    assign seqPc        = pc + ADDR_W'(4);
    assign branchOffset = {{(ADDR_W-IMM_HI-1){instrImm[IMM_HI]}}, instrImm} << 2;

    always_comb begin
        nextPc = seqPc;
        if (isJr) begin
            nextPc = rsValue;
        end else if (brTaken) begin
            nextPc = seqPc + branchOffset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: one instruction in flight, fetched from imem,
// issued to Control, and for branches held until the outcome steers the PC.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    fetchState_e        state, stateNext;
    logic [ADDR_W-1:0]  pc, pcNext, branchPc;
    logic [INSTR_W-1:0] instrReg, instrNext;
    logic [CNT_W-1:0]   issueCount, countNext;
    logic [6:0]         opcode;

    assign opcode = instrReg[OPC_HI:OPC_LO];

    next_pc_calc #(.ADDR_W(ADDR_W)) uNextPc (
        .pc       (pc),
        .instrImm (instrReg[IMM_HI:0]),
        .brTaken  (bus.br_taken),
        .rsValue  (bus.rs_value),
        .isJr     (opcode == OP_JR),
        .nextPc   (branchPc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instrReg   <= '0;
            issueCount <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            instrReg   <= instrNext;
            issueCount <= countNext;
        end
    end

    // Handshake inputs are only looked at in the state that owns them.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        instrNext = instrReg;
        countNext = issueCount;
        unique case (state)
            IDLE: stateNext = FETCH;
            FETCH: begin
                if (bus.imem_ready) begin
                    instrNext = bus.imem_rdata;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.issue_ready) begin
                    countNext = issueCount + CNT_W'(1);
                    if (isBranch(opcode)) begin
                        stateNext = RESOLVE;
                    end else begin
                        pcNext    = pc + ADDR_W'(4);
                        stateNext = FETCH;
                    end
                end
            end
            RESOLVE: begin
                if (bus.br_valid) begin
                    pcNext    = branchPc;
                    stateNext = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // pc does not move during ISSUE, so it doubles as the issued PC.
    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc;
    assign bus.issue_valid = (state == ISSUE);
    assign bus.operation   = opcode;
    assign bus.instr       = instrReg;
    assign bus.issue_pc    = pc;
    assign bus.issue_count = issueCount;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus tasks queue expected fetch
// addresses and issue contents, a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .CNT_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic [31:0] instr;
        logic [31:0] pc;
    } issueExp_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] fetchQ[$];
    issueExp_t   issueQ[$];
    logic [31:0] countExp;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted fetch and every issue handshake consumes one expectation.
    always @(negedge clk) begin
        logic [31:0] expAddr;
        issueExp_t   e;
        if (rst_n && bus.imem_req && bus.imem_ready) begin
            if (fetchQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL fetch_unexpected: got addr 0x%08h, expected no fetch", bus.imem_addr);
            end else begin
                expAddr = fetchQ.pop_front();
                checkOutput("fetch_addr", bus.imem_addr, expAddr);
            end
        end
        if (rst_n && bus.issue_valid && bus.issue_ready) begin
            if (issueQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL issue_unexpected: got op 0x%02h, expected no issue", bus.operation);
            end else begin
                e = issueQ.pop_front();
                checkOutput("issue_op", 32'(bus.operation), 32'(e.op));
                checkOutput("issue_instr", bus.instr, e.instr);
                checkOutput("issue_pc", bus.issue_pc, e.pc);
            end
        end
    end

    task automatic waitReq();
        int n = 0;
        while (!bus.imem_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("wait_imem_req", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!bus.issue_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("wait_issue_valid", 32'(bus.issue_valid), 32'd1);
    endtask

    task automatic applyStimulusFetch(input logic [31:0] addr, input int latency, input logic [31:0] rdata);
        fetchQ.push_back(addr);
        waitReq();
        repeat (latency) begin
            @(posedge clk); #1;
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = rdata;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hA5A5_A5A5;
    endtask

    task automatic applyStimulusIssue(input logic [6:0] op, input logic [31:0] ins,
                                      input logic [31:0] pc, input int stall);
        issueExp_t e;
        e.op = op; e.instr = ins; e.pc = pc;
        issueQ.push_back(e);
        waitValid();
        bus.issue_ready = 1'b0;
        bus.imem_ready  = (stall > 0);
        bus.imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_valid", 32'(bus.issue_valid), 32'd1);
            checkOutput("stall_op", 32'(bus.operation), 32'(op));
            checkOutput("stall_instr", bus.instr, ins);
            checkOutput("stall_pc", bus.issue_pc, pc);
            checkOutput("stall_count", bus.issue_count, countExp);
        end
        bus.imem_ready  = 1'b0;
        bus.issue_ready = 1'b1;
        @(posedge clk); #1;
        bus.issue_ready = 1'b0;
        countExp++;
        checkOutput("issue_count", bus.issue_count, countExp);
    endtask

    task automatic applyStimulusResolve(input logic taken, input logic [31:0] rs, input int delay);
        bus.br_taken = taken;
        bus.rs_value = rs;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            checkOutput("resolve_wait_req", 32'(bus.imem_req), 32'd0);
        end
        bus.br_valid = 1'b1;
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        bus.br_taken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = '0;
        bus.issue_ready = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.rs_value    = '0;
        countExp        = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
        checkOutput("reset_count", bus.issue_count, 32'd0);
        checkOutput("reset_operation", 32'(bus.operation), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_imem_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk); #1;
        checkOutput("first_fetch_req", 32'(bus.imem_req), 32'd1);
        checkOutput("first_fetch_addr", bus.imem_addr, 32'h0);

        // Straight-line code
        applyStimulusFetch(32'h0, 3, 32'h6000_0000);
        applyStimulusIssue(7'h30, 32'h6000_0000, 32'h0, 0);
        applyStimulusFetch(32'h4, 0, 32'h6200_0123);
        applyStimulusIssue(7'h31, 32'h6200_0123, 32'h4, 0);
        applyStimulusFetch(32'h8, 1, 32'h6000_0044);
        applyStimulusIssue(7'h30, 32'h6000_0044, 32'h8, 0);
        applyStimulusFetch(32'hC, 0, 32'h1234_5678);
        applyStimulusIssue(7'h09, 32'h1234_5678, 32'hC, 0);

        // Taken branch back by two words: 0x10 + 4 - 8 = 0x0C
        applyStimulusFetch(32'h10, 0, 32'h8000_FFFE);
        applyStimulusIssue(7'h40, 32'h8000_FFFE, 32'h10, 0);
        applyStimulusResolve(1'b1, 32'hDEAD_0000, 0);
        applyStimulusFetch(32'hC, 2, 32'h6000_0000);
        applyStimulusIssue(7'h30, 32'h6000_0000, 32'hC, 0);

        // Same branch not taken falls through to 0x14
        applyStimulusFetch(32'h10, 0, 32'h8000_FFFE);
        applyStimulusIssue(7'h40, 32'h8000_FFFE, 32'h10, 0);
        applyStimulusResolve(1'b0, 32'h0000_0055, 2);

        // Jump register ignores br_taken
        applyStimulusFetch(32'h14, 1, 32'h8200_0000);
        applyStimulusIssue(7'h41, 32'h8200_0000, 32'h14, 0);
        applyStimulusResolve(1'b1, 32'h0000_0100, 1);

        // Backpressure with a stray imem_ready during ISSUE
        applyStimulusFetch(32'h100, 0, 32'h6000_0008);
        applyStimulusIssue(7'h30, 32'h6000_0008, 32'h100, 5);

        // PC wrap-around through the top of the address space
        applyStimulusFetch(32'h104, 0, 32'h8200_0000);
        applyStimulusIssue(7'h41, 32'h8200_0000, 32'h104, 0);
        applyStimulusResolve(1'b0, 32'hFFFF_FFFC, 0);
        applyStimulusFetch(32'hFFFF_FFFC, 0, 32'h6200_0000);
        applyStimulusIssue(7'h31, 32'h6200_0000, 32'hFFFF_FFFC, 0);
        applyStimulusFetch(32'h0, 0, 32'h6000_0000);
        applyStimulusIssue(7'h30, 32'h6000_0000, 32'h0, 0);

        // Reset lands on the same edge as imem_ready while fetching 0x4
        waitReq();
        checkOutput("prereset_addr", bus.imem_addr, 32'h4);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h8200_0000;
        rst_n          = 1'b0;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        checkOutput("midreset_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("midreset_issue_valid", 32'(bus.issue_valid), 32'd0);
        checkOutput("midreset_instr", bus.instr, 32'h0);
        checkOutput("midreset_operation", 32'(bus.operation), 32'd0);
        checkOutput("midreset_pc", bus.imem_addr, 32'h0);
        checkOutput("midreset_count", bus.issue_count, 32'd0);
        countExp = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset_idle_req", 32'(bus.imem_req), 32'd0);
        applyStimulusFetch(32'h0, 0, 32'h6200_0000);
        applyStimulusIssue(7'h31, 32'h6200_0000, 32'h0, 0);

        @(posedge clk); #1;
        checkOutput("fetchQ_drained", 32'(fetchQ.size()), 32'd0);
        checkOutput("issueQ_drained", 32'(issueQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
